// File: rtl/vga_capture.sv
// vga_capture: VGA sink that recovers pixel coordinates from a sampled VGA
// stream and writes every visible pixel to a framebuffer write port using
// {y[8:0], x[9:0]} addressing. Optional per-frame CRC-16-CCITT over the
// written pixels is enabled by defining VGA_CAPTURE_CRC_EN.
module vga_capture #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        blank,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        frame_done,
  output logic        frame_error,
  output logic        overflow,
`ifdef VGA_CAPTURE_CRC_EN
  output logic [15:0] frame_crc,
`endif
  output logic        locked
);

  typedef enum logic {WAIT_VSYNC, ACTIVE} state_t;

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

  state_t     state, state_next;
  logic       vga_clk_d;
  logic       strobe;
  logic       hs, vs;
  logic       hs_d, vs_d, blank_d;
  logic [9:0] x;
  logic [8:0] y;
  logic       frame_ovf;
  logic       vs_rise, blank_fall;
  logic       pix_write, pix_over;
  logic       unused_hs;

  assign strobe     = vga_clk & ~vga_clk_d;
  assign hs         = h_sync ^ SYNC_ACTIVE_LOW;
  assign vs         = v_sync ^ SYNC_ACTIVE_LOW;
  assign vs_rise    = strobe & vs & ~vs_d;
  assign blank_fall = strobe & blank_d & ~blank;
  // Line sync is tracked for a planned line-sanity check but drives nothing yet.
  assign unused_hs  = hs_d;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= WAIT_VSYNC;
    else        state <= state_next;
  end

  // Next state and per-strobe pixel classification; vsync takes priority over pixels.
  always_comb begin
    state_next = state;
    pix_write  = 1'b0;
    pix_over   = 1'b0;
    case (state)
      WAIT_VSYNC: begin
        if (vs_rise) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (strobe && !vs_rise && blank) begin
          if ((x < H_LIM) && (y < V_LIM)) pix_write = 1'b1;
          else                            pix_over  = 1'b1;
        end
      end
      default: state_next = WAIT_VSYNC;
    endcase
  end

  // Edge-detection history: pixel clock every cycle, sync/blank once per pixel.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vga_clk_d <= 1'b0;
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      blank_d   <= 1'b0;
    end else begin
      vga_clk_d <= vga_clk;
      if (strobe) begin
        hs_d    <= hs;
        vs_d    <= vs;
        blank_d <= blank;
      end
    end
  end

  // Coordinate counters, write port and frame status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      frame_ovf   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      wr_en       <= pix_write;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (pix_write) begin
        wr_addr <= {y, x};
        wr_data <= {red, green, blue};
      end
      if (state == WAIT_VSYNC) begin
        if (vs_rise) begin
          locked    <= 1'b1;
          x         <= '0;
          y         <= '0;
          frame_ovf <= 1'b0;
        end
      end else if (strobe) begin
        if (vs_rise) begin
          if ((y == V_LIM) && !frame_ovf) frame_done  <= 1'b1;
          else                            frame_error <= 1'b1;
          x         <= '0;
          y         <= '0;
          frame_ovf <= 1'b0;
        end else if (blank_fall) begin
          x <= '0;
          if (y != 9'd511) y <= y + 9'd1;
        end else if (pix_write) begin
          x <= x + 10'd1;
        end else if (pix_over) begin
          overflow  <= 1'b1;
          frame_ovf <= 1'b1;
          if (x != 10'd1023) x <= x + 10'd1;
        end
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_acc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Per-frame CRC: fold each written pixel in, publish and restart at frame end.
  always_ff @(posedge clock) begin
    if (!reset) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else if ((state == ACTIVE) && vs_rise) begin
      frame_crc <= crc_acc;
      crc_acc   <= 16'hFFFF;
    end else if (wr_en) begin
      crc_acc <= crc_step(crc_acc, wr_data);
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed stimulus for vga_capture on a reduced 16x12 raster.
// A behavioural model predicts every framebuffer write and every frame-end
// pulse from the geometry of the frames the bench itself generates.
module tb_vga_capture;

  localparam int H = 16;
  localparam int V = 12;

  logic        clock;
  logic        reset;
  logic        vga_clk;
  logic        h_sync;
  logic        v_sync;
  logic        blank;
  logic [7:0]  red, green, blue;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        frame_done;
  logic        frame_error;
  logic        overflow;
  logic        locked;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
`endif

  vga_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .vga_clk(vga_clk),
    .h_sync(h_sync),
    .v_sync(v_sync),
    .blank(blank),
    .red(red),
    .green(green),
    .blue(blue),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .frame_error(frame_error),
    .overflow(overflow),
`ifdef VGA_CAPTURE_CRC_EN
    .frame_crc(frame_crc),
`endif
    .locked(locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model state: predicted writes, predicted frame-end pulses (1 = done, 0 = error).
  logic [18:0] expAddrQ[$];
  logic [23:0] expDataQ[$];
  bit          expEvtQ[$];
  bit          tbLocked;
  int          lineCount;
  bit          frameOver;
  bit          expOverflow;
  logic [15:0] modelCrc;
  logic [15:0] expFrameCrc;

  // Observations gathered by the compare process.
  int          writeCount;
  int          doneCount;
  int          errorCount;
  logic [18:0] firstAddr;
  logic [18:0] lastAddr;
  logic [23:0] lastData;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] crcUpdate(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    bit fb;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Pattern 0: x^y in red; pattern 1: all zero; pattern 2: zero except one pixel at (10,5).
  function automatic logic [23:0] pixelValue(input int mode, input int px, input int ln);
    case (mode)
      0:       return {8'(px ^ ln), 8'(px), 8'(ln)};
      1:       return 24'h000000;
      default: return ((px == 10) && (ln == 5)) ? 24'h000080 : 24'h000000;
    endcase
  endfunction

  task automatic clearModel();
    expAddrQ.delete();
    expDataQ.delete();
    expEvtQ.delete();
    tbLocked    = 1'b0;
    lineCount   = 0;
    frameOver   = 1'b0;
    expOverflow = 1'b0;
    modelCrc    = 16'hFFFF;
    expFrameCrc = 16'h0000;
  endtask

  task automatic clearObs();
    writeCount = 0;
    doneCount  = 0;
    errorCount = 0;
  endtask

  // One pixel period = two system clocks; syncs are given as asserted (1) and driven active low.
  task automatic applyStimulus(input bit hsA, input bit vsA, input bit blankA, input logic [23:0] rgb);
    @(negedge clock);
    vga_clk = 1'b1;
    h_sync  = ~hsA;
    v_sync  = ~vsA;
    blank   = blankA;
    {red, green, blue} = rgb;
    @(negedge clock);
    vga_clk = 1'b0;
  endtask

  task automatic sendPixel(input int px, input int ln, input int mode);
    logic [23:0] d;
    d = pixelValue(mode, px, ln);
    if (tbLocked) begin
      if ((lineCount < V) && (px < H)) begin
        expAddrQ.push_back({9'(lineCount), 10'(px)});
        expDataQ.push_back(d);
        modelCrc = crcUpdate(modelCrc, d);
      end else begin
        frameOver   = 1'b1;
        expOverflow = 1'b1;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1, d);
  endtask

  // Visible pixels followed by a short blanking interval carrying the line sync.
  task automatic sendLine(input int ln, input int npix, input int mode);
    for (int p = 0; p < npix; p++) sendPixel(p, ln, mode);
    if (tbLocked) lineCount++;
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic sendVsync();
    if (tbLocked) begin
      expEvtQ.push_back((lineCount == V) && !frameOver);
      expFrameCrc = modelCrc;
      modelCrc    = 16'hFFFF;
    end
    tbLocked  = 1'b1;
    lineCount = 0;
    frameOver = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic sendFrame(input int nLines, input int wideLine, input int wideWidth, input int mode);
    for (int l = 0; l < nLines; l++) sendLine(l, (l == wideLine) ? wideWidth : H, mode);
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset   = 1'b0;
    blank   = 1'b1;
    red     = 8'hA5;
    green   = 8'h5A;
    blue    = 8'h3C;
    clearModel();
    repeat (3) begin
      @(negedge clock);
      vga_clk = ~vga_clk;
    end
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_frame_error", 32'(frame_error), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
`ifdef VGA_CAPTURE_CRC_EN
    checkOutput("rst_frame_crc", 32'(frame_crc), 32'd0);
`endif
    @(negedge clock);
    reset   = 1'b1;
    vga_clk = 1'b0;
    blank   = 1'b0;
    {red, green, blue} = 24'h0;
    clearObs();
  endtask

  // Compare process: every write and every frame-end pulse is matched against the model.
  always @(negedge clock) begin
    logic [18:0] ea;
    logic [23:0] ed;
    bit          ev;
    if (wr_en) begin
      writeCount++;
      if (writeCount == 1) firstAddr = wr_addr;
      lastAddr = wr_addr;
      lastData = wr_data;
      if (expAddrQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        ea = expAddrQ.pop_front();
        ed = expDataQ.pop_front();
        checkOutput("wr_addr", 32'(wr_addr), 32'(ea));
        checkOutput("wr_data", 32'(wr_data), 32'(ed));
      end
    end
    if (frame_done && frame_error) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_and_error: got both 1, expected at most one");
    end
    if (frame_done || frame_error) begin
      if (frame_done)  doneCount++;
      if (frame_error) errorCount++;
      if (expEvtQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_frame_pulse: got done=%0b error=%0b, expected none", frame_done, frame_error);
      end else begin
        ev = expEvtQ.pop_front();
        checkOutput("frame_done", 32'(frame_done), 32'(ev));
        checkOutput("frame_error", 32'(frame_error), 32'(!ev));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crcZero;
`endif
    reset   = 1'b0;
    vga_clk = 1'b0;
    h_sync  = 1'b1;
    v_sync  = 1'b1;
    blank   = 1'b0;
    {red, green, blue} = 24'h0;
    clearModel();
    clearObs();

    // Reset with the pixel clock toggling.
    $display("[TB] reset");
    applyReset();

    // Full frame with x^y pattern.
    $display("[TB] full frame");
    sendVsync();
    checkOutput("locked_after_vs", 32'(locked), 32'd1);
    sendFrame(V, -1, H, 0);
    sendVsync();
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("full_write_count", 32'(writeCount), 32'd192);
    checkOutput("full_first_addr", 32'(firstAddr), 32'h00000);
    checkOutput("full_last_addr", 32'(lastAddr), 32'h02C0F);
    checkOutput("full_last_data", 32'(lastData), 32'h040F0B);
    checkOutput("addr_hold", 32'(wr_addr), 32'h02C0F);
    checkOutput("full_done_count", 32'(doneCount), 32'd1);
    checkOutput("full_error_count", 32'(errorCount), 32'd0);
    checkOutput("full_overflow", 32'(overflow), 32'(expOverflow));

    // Capture starting mid-frame.
    $display("[TB] mid-frame start");
    applyReset();
    for (int l = 6; l < V; l++) sendLine(l, H, 0);
    checkOutput("mid_no_writes", 32'(writeCount), 32'd0);
    checkOutput("mid_not_locked", 32'(locked), 32'd0);
    sendVsync();
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("mid_no_pulse", 32'(doneCount + errorCount), 32'd0);
    sendFrame(V, -1, H, 0);
    sendVsync();
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("mid_done_count", 32'(doneCount), 32'd1);

    // Frame one line short.
    $display("[TB] short frame");
    clearObs();
    sendFrame(V - 1, -1, H, 0);
    sendVsync();
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("short_write_count", 32'(writeCount), 32'd176);
    checkOutput("short_error_count", 32'(errorCount), 32'd1);
    checkOutput("short_done_count", 32'(doneCount), 32'd0);
    checkOutput("short_overflow", 32'(overflow), 32'd0);

    // Frame with one over-long line, then a good frame: overflow stays set.
    $display("[TB] wide line");
    clearObs();
    sendFrame(V, 3, H + 2, 0);
    sendVsync();
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("wide_write_count", 32'(writeCount), 32'd192);
    checkOutput("wide_overflow", 32'(overflow), 32'd1);
    checkOutput("wide_error_count", 32'(errorCount), 32'd1);
    sendFrame(V, -1, H, 0);
    sendVsync();
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("after_wide_done", 32'(doneCount), 32'd1);
    checkOutput("overflow_sticky", 32'(overflow), 32'(expOverflow));

    // Reset in the middle of a visible line.
    $display("[TB] reset mid-line");
    clearObs();
    for (int p = 0; p < 4; p++) sendPixel(p, 0, 0);
    @(negedge clock);
    reset   = 1'b0;
    vga_clk = 1'b1;
    blank   = 1'b1;
    red     = 8'hFF;
    clearModel();
    @(negedge clock);
    vga_clk = 1'b0;
    checkOutput("midrst_no_write", 32'(wr_en), 32'd0);
    checkOutput("midrst_locked", 32'(locked), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    clearObs();
    sendLine(1, H, 0);
    checkOutput("midrst_idle_writes", 32'(writeCount), 32'd0);

`ifdef VGA_CAPTURE_CRC_EN
    // Per-frame CRC over an all-zero frame and over a frame differing in one pixel.
    $display("[TB] frame crc");
    applyReset();
    sendVsync();
    sendFrame(V, -1, H, 1);
    sendVsync();
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("crc_zero_frame", 32'(frame_crc), 32'(expFrameCrc));
    crcZero = frame_crc;
    sendFrame(V, -1, H, 2);
    sendVsync();
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("crc_one_pixel", 32'(frame_crc), 32'(expFrameCrc));
    checks++;
    if (frame_crc === crcZero) begin
      failures++;
      $display("[TB] FAIL crc_differs: got 0x%0h, expected a value other than 0x%0h", frame_crc, crcZero);
    end
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("pending_writes", 32'(expAddrQ.size()), 32'd0);
    checkOutput("pending_pulses", 32'(expEvtQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- VGA sink: samples the pixel stream driven by the `vga` controller (sync, blank, RGB, pixel clock) and recovers x/y pixel coordinates.
- Writes every visible pixel into a framebuffer write port using the same addressing as `display_buffer`: {y[8:0], x[9:0]}.
- Used for loopback self-check and simulation frame dumps; sits beside `vga`, fed from the same VGA_* nets.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- SYNC_ACTIVE_LOW, 1, when 1 h_sync/v_sync assert low, else high.

Ports:
- clock  in  1  system clock; frequency at least 2x vga_clk.
- reset  in  1  synchronous, active-low reset.
- vga_clk  in  1  pixel clock from `vga` target_clock; sampled as data, not used as a clock.
- h_sync  in  1  horizontal sync.
- v_sync  in  1  vertical sync.
- blank  in  1  VGA_BLANK_N semantics: 1 = visible pixel.
- red, green, blue  in  8 each  pixel colour.
- wr_en  out  1  framebuffer write strobe, one clock wide.
- wr_addr  out  19  {y[8:0], x[9:0]}.
- wr_data  out  24  pixel_t {red, green, blue}.
- frame_done  out  1  one-clock pulse at the end of a complete frame.
- frame_error  out  1  one-clock pulse at the end of a malformed frame.
- overflow  out  1  sticky flag: pixels seen beyond H_ACTIVE or V_ACTIVE.
- locked  out  1  high after the first v_sync has been seen.

Behaviour:
- Reset (reset==0 at a clock edge): all outputs 0, x=0, y=0, state=WAIT_VSYNC, edge registers cleared.
- Pixel strobe: registered vga_clk_d; strobe = vga_clk & ~vga_clk_d. All inputs are sampled in the clock cycle where strobe=1.
- Sync normalisation: hs = h_sync ^ SYNC_ACTIVE_LOW, vs = v_sync ^ SYNC_ACTIVE_LOW. hs/vs = 1 means asserted.
- State WAIT_VSYNC:
  - no writes.
  - on a strobe with a vs rising edge (vs previously 0): go to ACTIVE, locked<=1, x=0, y=0.
- State ACTIVE, on each strobe:
  - blank=1 and x<H_ACTIVE and y<V_ACTIVE: wr_en=1 on the next clock, with wr_addr={y,x} and wr_data of the current sample; then x<=x+1.
  - blank=1 and (x>=H_ACTIVE or y>=V_ACTIVE): no write, overflow<=1, x saturates at 1023.
  - blank falling edge (previous strobe's blank=1, current blank=0): x<=0, y<=y+1 (saturates at 511).
  - vs rising edge: if y==V_ACTIVE and no overflow occurred in this frame, pulse frame_done; otherwise pulse frame_error. Then x<=0, y<=0.
- Latency: wr_en is asserted exactly 1 clock after the strobe cycle. Outputs are registered.
- wr_addr/wr_data hold their last value while wr_en=0.
- hs is tracked only for a future check; it does not affect counters. Line advance is driven by blank only.
- Simultaneous vs rising edge and blank falling edge on the same strobe: the vs action wins; y resets to 0, not incremented.
- Partial first frame (capture starts mid-frame): discarded, because WAIT_VSYNC ignores everything before the first vs edge. No frame_done or frame_error is pulsed for it.
- frame_done and frame_error never assert in the same cycle.
- overflow is cleared only by reset.
- Reset mid-line: returns to WAIT_VSYNC; no write is issued in the cycle following reset.

Optional Feature:
- Macro: VGA_CAPTURE_CRC_EN.
- Defined:
  - Adds output frame_crc [15:0].
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates the 24 wr_data bits, MSB first, on every wr_en.
  - At a vs rising edge in ACTIVE state, frame_crc latches the accumulator and the accumulator reinitialises to 0xFFFF.
  - frame_crc resets to 0x0000.
- Undefined: no frame_crc port and no CRC logic; all other behaviour is identical.

Test Plan:
1. Reset held 0 for 3 clocks, with toggling vga_clk -> all outputs 0, locked=0, no wr_en.
2. 640x480 frame with pixel=x^y pattern, clock = 2x vga_clk:
   - locked=1 after the first vs edge.
   - 307200 wr_en pulses, the first at addr 0x00000 and the last at {9'd479, 10'd639} = 0x77E7F.
   - frame_done pulses once at the next vs edge.
3. Capture starts mid-frame at line 200 -> zero writes until the first vs edge; no frame_done or frame_error for the partial frame; the following full frame gives frame_done.
4. Frame with only 479 visible lines -> frame_error pulses once, frame_done stays 0, overflow stays 0.
5. Line with 642 visible pixels -> exactly 640 writes on that line, overflow=1 (sticky), frame_error at the next vs edge.
6. (VGA_CAPTURE_CRC_EN) all-zero 640x480 frame -> frame_crc equals the reference-model CRC of 307200 zero 24-bit words. A single-pixel change at (10,5) -> a different frame_crc.
